seg7_scan_driver: RTL

Time-multiplexed 4-digit 7-segment display driver that sits directly downstream of the MM:SS stopwatch counter chain. It consumes the 16 packed BCD outputs (S0, S1, M0, M1) and drives one shared active-low segment bus plus four active-low digit anodes. Each digit is scanned in turn with an anti-ghosting blank interval, and the MM:SS colon can blink. Input data is snapshotted once per frame so the display never shows digits from two different counts.

---
 rtl/seg7_scan_driver.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed 4-digit 7-segment driver for an MM:SS display. Scans one
// digit per slot of REFRESH_DIV cycles. The first BLANK_CYC cycles of every
// slot keep all anodes off (anti-ghosting). The BCD input is snapshotted once
// per frame, so a frame never mixes digits from two different counts. The
// colon (DP on the M0 digit) can blink every BLINK_FRAMES frames.
//
// Optional feature (compile-time macro):
//   SEG7_LZ_BLANK_EN : blank the M1 digit when it is zero (" 5:30").
//
// Ports:
//   CLK   in   1   system clock, rising edge
//   RST   in   1   asynchronous, active-low reset
//   BCD   in  16   packed digits {M1, M0, S1, S0}
//   BLINK in   1   1 = colon blinks, 0 = colon steady on
//   SEG   out  7   segments {g,f,e,d,c,b,a}, active-low
//   DP    out  1   decimal point used as the colon, active-low
//   AN    out  4   digit anodes, active-low; AN[0] = S0 ... AN[3] = M1
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYC    = 4,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] BCD,
    input  logic        BLINK,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [3:0]  AN
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    logic [PW-1:0] pcnt;
    logic [1:0]    idx;
    logic [FW-1:0] fcnt;
    logic          blink_ph;
    logic [15:0]   snap;

    logic          slot_end;
    logic          frame_end;
    logic          frame_start;
    logic [15:0]   snap_eff;
    logic [3:0]    digit;
    logic          active;
    logic [6:0]    glyph;
    logic [6:0]    seg_next;
    logic          dp_next;
    logic [3:0]    an_next;

    assign slot_end    = (pcnt == PW'(REFRESH_DIV - 1));
    assign frame_end   = slot_end && (idx == 2'd3);
    assign frame_start = (pcnt == '0) && (idx == 2'd0);

    // The snapshot register loads on the same edge that starts the frame, so
    // decode looks through to BCD on that edge. This only matters when
    // BLANK_CYC is 0 and the first frame cycle is already visible.
    assign snap_eff = frame_start ? BCD : snap;

    // NOTE: every signal assigned in always_comb gets a default first so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        digit = 4'd0;
        case (idx)
            2'd0: digit = snap_eff[3:0];
            2'd1: digit = snap_eff[7:4];
            2'd2: digit = snap_eff[11:8];
            2'd3: digit = snap_eff[15:12];
            default: digit = 4'd0;
        endcase

        glyph = SEG_DASH;
        case (digit)
            4'd0: glyph = 7'b1000000;
            4'd1: glyph = 7'b1111001;
            4'd2: glyph = 7'b0100100;
            4'd3: glyph = 7'b0110000;
            4'd4: glyph = 7'b0011001;
            4'd5: glyph = 7'b0010010;
            4'd6: glyph = 7'b0000010;
            4'd7: glyph = 7'b1111000;
            4'd8: glyph = 7'b0000000;
            4'd9: glyph = 7'b0010000;
            default: glyph = SEG_DASH;
        endcase

        active = (pcnt >= PW'(BLANK_CYC));
`ifdef SEG7_LZ_BLANK_EN
        // Leading-zero blanking: the M1 slot keeps its timing but stays dark.
        if (idx == 2'd3 && snap_eff[15:12] == 4'd0) begin
            active = 1'b0;
        end
`endif

        seg_next = active ? glyph : SEG_OFF;
        an_next  = active ? ~(4'b0001 << idx) : 4'b1111;
        dp_next  = ~(active && (idx == 2'd2) && (!BLINK || blink_ph));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pcnt     <= '0;
            idx      <= 2'd0;
            fcnt     <= '0;
            blink_ph <= 1'b1;
            snap     <= 16'h0000;
            SEG      <= SEG_OFF;
            DP       <= 1'b1;
            AN       <= 4'b1111;
        end else begin
            if (frame_start) begin
                snap <= BCD;
            end

            if (slot_end) begin
                pcnt <= '0;
                idx  <= idx + 2'd1;
            end else begin
                pcnt <= pcnt + PW'(1);
            end

            // Frame counter advances on the last cycle of a frame, so the
            // colon phase changes exactly at a frame boundary.
            if (frame_end) begin
                if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                    fcnt     <= '0;
                    blink_ph <= ~blink_ph;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end

            SEG <= seg_next;
            DP  <= dp_next;
            AN  <= an_next;
        end
    end

endmodule
